sqrt_square: RTL and testbench

- Iterative fixed-point squarer; the inverse of the team's `sqrt` block. It takes `root` and `rem` and reconstructs `rad = (root*root + rem) >> FBITS`.
- Used in secret-key-length calculation to cross-check square-root results and to rebuild squared statistical terms.
- Uses the same `start`/`busy`/`valid` convention as `sqrt`: one shift-add multiplier step per cycle.

---
 rtl/sqrt_pkg.sv | 23 ++
 rtl/sqrt_square_step.sv | 46 ++++
 rtl/sqrt_square.sv | 104 ++++++++++
 tb/tb_sqrt_square.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared definitions for the sqrt / sqrt_square blocks: default operand
// geometry, the iteration count of the squarer and its FSM state encoding.
// Build option: define SQRT_SQUARE_RADIX4_EN for the two-bits-per-cycle squarer.
package sqrt_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_FBITS = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sq_state_t;

    // Number of multiplier steps the squarer needs for a given operand width.
    function automatic int sq_iter(input int width);
`ifdef SQRT_SQUARE_RADIX4_EN
        return width / 2;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/sqrt_square_step.sv
// One shift-add multiplier step of the squarer (purely combinational).
// Radix-2 consumes one multiplier bit per step; with SQRT_SQUARE_RADIX4_EN
// defined it consumes two bits, adding 0, 1, 2 or 3 times the multiplicand.
module sqrt_square_step #(
    parameter int WIDTH = 64
) (
    input  logic [2*WIDTH:0]   acc,
    input  logic [2*WIDTH-1:0] mc,
    input  logic [WIDTH-1:0]   mp,
    output logic [2*WIDTH:0]   acc_next,
    output logic [2*WIDTH-1:0] mc_next,
    output logic [WIDTH-1:0]   mp_next
);

`ifdef SQRT_SQUARE_RADIX4_EN
    // The multiplicand never exceeds 2^(2*WIDTH-2) here, so 2*mc and 3*mc fit
    // the accumulator width and the sum never wraps.
    logic [2*WIDTH:0] mc_x1;
    logic [2*WIDTH:0] mc_x2;
    logic [2*WIDTH:0] partial;

    assign mc_x1 = {1'b0, mc};
    assign mc_x2 = {mc, 1'b0};

    // Select the partial product for the two low multiplier bits.
    always_comb begin
        // NOTE: default assignment first so no path leaves partial unassigned (no latch).
        partial = '0;
        case (mp[1:0])
            2'd1:    partial = mc_x1;
            2'd2:    partial = mc_x2;
            2'd3:    partial = mc_x1 + mc_x2;
            default: partial = '0;
        endcase
    end

    assign acc_next = acc + partial;
    assign mc_next  = {mc[2*WIDTH-3:0], 2'b00};
    assign mp_next  = {2'b00, mp[WIDTH-1:2]};
`else
    assign acc_next = mp[0] ? (acc + {1'b0, mc}) : acc;
    assign mc_next  = {mc[2*WIDTH-2:0], 1'b0};
    assign mp_next  = {1'b0, mp[WIDTH-1:1]};
`endif

endmodule

// File: rtl/sqrt_square.sv
// Iterative fixed-point squarer: rad = (root*root + rem) >> FBITS, the inverse
// of the sqrt block. Fixed latency of sq_iter(WIDTH) cycles after start.
// Build option: SQRT_SQUARE_RADIX4_EN halves the latency (two bits per cycle);
// results are identical in both builds.
module sqrt_square
    import sqrt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int FBITS = DEFAULT_FBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] root,
    input  logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] rad,
    output logic             ovf,
    output logic             frac_nz
);

    localparam int ITER = sq_iter(WIDTH);
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    sq_state_t state, state_next;

    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH-1:0] mc;
    logic [WIDTH-1:0]   mp;
    logic [CW-1:0]      cnt;

    logic [2*WIDTH:0]   acc_step;
    logic [2*WIDTH-1:0] mc_step;
    logic [WIDTH-1:0]   mp_step;
    logic               last;
    logic               frac_bits_nz;

    sqrt_square_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .mc       (mc),
        .mp       (mp),
        .acc_next (acc_step),
        .mc_next  (mc_step),
        .mp_next  (mp_step)
    );

    assign last = (cnt == LAST);
    assign busy = (state == RUN);

    // With no fractional bits the result can never be inexact.
    if (FBITS == 0) begin : g_no_frac
        assign frac_bits_nz = 1'b0;
    end else begin : g_frac
        assign frac_bits_nz = |acc_step[FBITS-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: start (re)enters RUN from anywhere; the last step returns to IDLE.
    always_comb begin
        state_next = state;
        if (start)                   state_next = RUN;
        else if (state == RUN && last) state_next = IDLE;
    end

    // Operand/accumulator datapath and result registers; start aborts any run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mc      <= '0;
            mp      <= '0;
            cnt     <= '0;
            rad     <= '0;
            ovf     <= 1'b0;
            frac_nz <= 1'b0;
            valid   <= 1'b0;
        end else if (start) begin
            acc   <= {{(WIDTH+1){1'b0}}, rem};
            mc    <= {{WIDTH{1'b0}}, root};
            mp    <= root;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (state == RUN) begin
            acc <= acc_step;
            mc  <= mc_step;
            mp  <= mp_step;
            cnt <= cnt + 1'b1;
            if (last) begin
                rad     <= acc_step[WIDTH+FBITS-1:FBITS];
                ovf     <= |acc_step[2*WIDTH:WIDTH+FBITS];
                frac_nz <= frac_bits_nz;
                valid   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sqrt_square.sv
// Directed bench for sqrt_square (WIDTH=64, FBITS=32). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_sqrt_square;

    localparam int WIDTH = 64;
    localparam int FBITS = 32;
`ifdef SQRT_SQUARE_RADIX4_EN
    localparam int LAT = WIDTH / 2;
`else
    localparam int LAT = WIDTH;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] root;
    logic [WIDTH-1:0] rem;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] rad;
    logic             ovf;
    logic             frac_nz;

    int checks;
    int failures;

    sqrt_square #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .root    (root),
        .rem     (rem),
        .busy    (busy),
        .valid   (valid),
        .rad     (rad),
        .ovf     (ovf),
        .frac_nz (frac_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference integer square root: floor(sqrt(n)) for n < 2^128.
    function automatic logic [63:0] isqrt(input logic [127:0] n);
        logic [127:0] r;
        logic [127:0] t;
        r = '0;
        for (int b = 63; b >= 0; b--) begin
            t = r | (128'd1 << b);
            if (t * t <= n) r = t;
        end
        return r[63:0];
    endfunction

    // Pulse start with the given operands, scramble the operand inputs while
    // the run is in progress, and wait (bounded) for valid.
    // lat = rising edges from the start edge until valid is seen (-1 on timeout).
    task automatic run_op(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] m,
                          output int lat, output int busy_cnt);
        int n;
        @(negedge clk);
        root  = r;
        rem   = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        root  = {$urandom, $urandom};
        rem   = {$urandom, $urandom};
        n = 1;
        busy_cnt = 0;
        while (!valid && n < 4 * WIDTH) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        lat = valid ? n - 1 : -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        root  = '0;
        rem   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, valid, rad, ovf, frac_nz} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b valid=%b rad=%h ovf=%b frac_nz=%b want all 0",
                     busy, valid, rad, ovf, frac_nz);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b valid=%b want 0 0", busy, valid);
        end
    endtask

    task automatic test_square_two();
        int lat, bc;
        run_op(64'h2_0000_0000, 64'h0, lat, bc);
        checks++;
        if (lat !== LAT) begin
            failures++;
            $display("FAIL two_latency got %0d want %0d", lat, LAT);
        end
        checks++;
        if (bc !== LAT) begin
            failures++;
            $display("FAIL two_busy_cycles got %0d want %0d", bc, LAT);
        end
        checks++;
        if (rad !== 64'h4_0000_0000 || ovf !== 1'b0 || frac_nz !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL two_result got rad=%h ovf=%b frac_nz=%b busy=%b want 400000000 0 0 0",
                     rad, ovf, frac_nz, busy);
        end
        // Result must hold while idle.
        repeat (10) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || rad !== 64'h4_0000_0000) begin
            failures++;
            $display("FAIL two_hold got valid=%b rad=%h want 1 400000000", valid, rad);
        end
    endtask

    task automatic test_fraction();
        int lat, bc;
        run_op(64'h1_8000_0000, 64'h0, lat, bc);
        checks++;
        if (lat !== LAT || rad !== 64'h2_4000_0000 || ovf !== 1'b0 || frac_nz !== 1'b0) begin
            failures++;
            $display("FAIL one_point_five got lat=%0d rad=%h ovf=%b frac_nz=%b want %0d 240000000 0 0",
                     lat, rad, ovf, frac_nz, LAT);
        end
        run_op(64'h0, 64'h1, lat, bc);
        checks++;
        if (rad !== 64'h0 || ovf !== 1'b0 || frac_nz !== 1'b1) begin
            failures++;
            $display("FAIL rem_only_inexact got rad=%h ovf=%b frac_nz=%b want 0 0 1", rad, ovf, frac_nz);
        end
        run_op(64'h0, 64'h1_0000_0000, lat, bc);
        checks++;
        if (rad !== 64'h1 || ovf !== 1'b0 || frac_nz !== 1'b0) begin
            failures++;
            $display("FAIL rem_one_lsb got rad=%h ovf=%b frac_nz=%b want 1 0 0", rad, ovf, frac_nz);
        end
    endtask

    task automatic test_overflow();
        int lat, bc;
        run_op(64'h1_0000_0000_0000, 64'h0, lat, bc);
        checks++;
        if (rad !== 64'h0 || ovf !== 1'b1 || frac_nz !== 1'b0) begin
            failures++;
            $display("FAIL ovf_2p48 got rad=%h ovf=%b frac_nz=%b want 0 1 0", rad, ovf, frac_nz);
        end
        // Largest operands: (2^64-1)^2 + 2^64-1 = 2^128 - 2^64.
        run_op('1, '1, lat, bc);
        checks++;
        if (rad !== 64'hFFFF_FFFF_0000_0000 || ovf !== 1'b1 || frac_nz !== 1'b0) begin
            failures++;
            $display("FAIL max_operands got rad=%h ovf=%b frac_nz=%b want ffffffff00000000 1 0",
                     rad, ovf, frac_nz);
        end
    endtask

    task automatic test_round_trip();
        int lat, bc;
        int bad;
        logic [WIDTH-1:0] x;
        logic [127:0]     scaled;
        logic [WIDTH-1:0] r;
        logic [127:0]     m;
        bad = 0;
        for (int k = 0; k <= 1000; k++) begin
            x = (k == 0) ? 64'h0000_0002_0000_0000 : {$urandom, $urandom};
            scaled = {64'h0, x} << FBITS;
            r = isqrt(scaled);
            m = scaled - {64'h0, r} * {64'h0, r};
            run_op(r, m[63:0], lat, bc);
            checks++;
            if (lat !== LAT || rad !== x || ovf !== 1'b0 || frac_nz !== 1'b0) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL round_trip[%0d] got lat=%0d rad=%h ovf=%b frac_nz=%b want %0d %h 0 0",
                             k, lat, rad, ovf, frac_nz, LAT, x);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        // Start a new op right after a valid result: valid must clear on the start edge.
        @(negedge clk);
        root  = 64'h3_0000_0000;
        rem   = 64'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_clears_valid got valid=%b busy=%b want 0 1", valid, busy);
        end
        // Restart mid-run (cycle 20) with new operands.
        repeat (18) @(negedge clk);
        run_op(64'h3_0000_0000, 64'h0, lat, bc);
        checks++;
        if (lat !== LAT || rad !== 64'h9_0000_0000 || ovf !== 1'b0 || frac_nz !== 1'b0) begin
            failures++;
            $display("FAIL restart got lat=%0d rad=%h ovf=%b frac_nz=%b want %0d 900000000 0 0",
                     lat, rad, ovf, frac_nz, LAT);
        end
    endtask

    task automatic test_abort_reset();
        int seen;
        @(negedge clk);
        root  = 64'h2_0000_0000;
        rem   = 64'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (LAT / 2 - 2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_before_abort got %b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, valid, rad, ovf, frac_nz} !== '0) begin
            failures++;
            $display("FAIL async_reset got busy=%b valid=%b rad=%h ovf=%b frac_nz=%b want all 0",
                     busy, valid, rad, ovf, frac_nz);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (2 * LAT) begin
            @(negedge clk);
            if (valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL no_result_after_abort got %0d active cycles want 0", seen);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_square_two();
        test_fraction();
        test_overflow();
        test_back_to_back();
        test_round_trip();
        test_abort_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
